rgb2bayer_em: RTL and testbench
===============================

Name: rgb2bayer_em

Overview:
- Sensor-side emulator: re-mosaics an RGB pixel stream (fv/lv plus R/G/B) into an 8-bit Bayer stream with embedded sync codes.
- Output has the same form the camera-input path decodes, so the capture pipeline can be looped back and tested without a sensor.
- Sits after any RGB source (test pattern, RGB stage output) and drives the camera data bus in place of the CMOS sensor.

Parameters:
- BAYER_PAT, 0: mosaic order of first frame line. 0=GBRG, 1=GRBG, 2=BGGR, 3=RGGB.
- MIN_HBLANK, 8: minimum lv-low gap (cycles) for SAV/EAV to fit without collision.

Ports:
- pixclk  in  1  pixel clock; single clock domain.
- rst  in  1  synchronous reset, active-low, sampled on pixclk rising edge.
- rgb_fv  in  1  frame valid.
- rgb_lv  in  1  line valid; one pixel per cycle while high.
- data_r  in  8  red sample.
- data_g  in  8  green sample.
- data_b  in  8  blue sample.
- bayer_data  out  8  embedded-sync Bayer byte stream.
- bayer_fv  out  1  monitor: fv delayed, aligned to bayer_data.
- bayer_lv  out  1  monitor: high only on pixel bytes, aligned to bayer_data.
- sync_err  out  1  sticky: hblank shorter than MIN_HBLANK.

Behaviour:
- Reset (rst=0 at an edge): bayer_data=8'h10, bayer_fv=0, bayer_lv=0, sync_err=0. Row/column parity, delay line and state machine cleared. Reset mid-line aborts the line; no EAV is emitted.
- Input registered, then 4-stage delay line. Pixel sampled at cycle t appears on bayer_data at t+5. Latency is fixed at 5 for pixels and fv.
- Code words are 4 bytes: FF,00,00,XY, where XY = {1'b1, F=0, V, H, P3..P0}:
  - Active line (rgb_fv=1 at lv rise): SAV=8'h80, EAV=8'h9D.
  - Blanking line (rgb_fv=0 at lv rise): SAV=8'hAB, EAV=8'hB6.
  - V is latched at lv rise and held for the whole line, including its EAV.
- Output state machine:
  - IDLE: emit 8'h10.
  - SAV: 4 bytes at t+1..t+4, where t is the cycle rgb_lv rises.
  - PIX: delayed pixels.
  - EAV: 4 bytes immediately after the last pixel, i.e. last pixel in at te, EAV at te+6..te+9.
  - Then IDLE.
- Pixel byte selection:
  - Row parity r toggles at each active-line lv fall; cleared at rgb_fv rising edge.
  - Column parity c cleared at each lv rise, toggles per pixel.
  - GBRG: r=0 gives G,B,G,B…; r=1 gives R,G,R,G…. Other BAYER_PAT values follow their named order.
  - Blanking-line pixels are emitted as 8'h10.
- Clipping: pixel bytes 8'hFF become 8'hFE and 8'h00 become 8'h01, so payload never forms a false preamble.
- Collision: if a new SAV must start while EAV is still in flight (lv low gap < MIN_HBLANK), SAV wins. The remaining EAV bytes are dropped and sync_err is set; it clears only on reset.
- bayer_fv: rgb_fv delayed 5 cycles. bayer_lv: 1 exactly on PIX cycles of active lines.
- Line length is unrestricted. Lines of 1 pixel are legal: SAV, 1 pixel, EAV.
- lv rise and fv rise in the same cycle: row parity cleared first, and the line is active.

Test Plan:
- Reset, then hold rgb_fv=0, rgb_lv=0 for 20 cycles → bayer_data=8'h10 throughout, bayer_fv=bayer_lv=sync_err=0.
- BAYER_PAT=0, fv=1, two 4-pixel lines with gap 10; pixels R=8'h11, G=8'h22, B=8'h33 → line 0: FF 00 00 80 22 33 22 33 FF 00 00 9D; line 1: FF 00 00 80 11 22 11 22 FF 00 00 9D. First pixel byte appears 5 cycles after lv rise.
- One lv line of 3 pixels with fv=0 → FF 00 00 AB 10 10 10 FF 00 00 B6; bayer_lv stays 0.
- Active pixel with G=8'hFF then G=8'h00 on a G site → output bytes 8'hFE then 8'h01.
- Two lines with lv-low gap 3 cycles → second SAV FF 00 00 80 emitted on time, first EAV truncated, sync_err=1 and held. Then 10 clean lines → sync_err still 1.
- Assert rst=0 during PIX of line 2, release, start new frame → immediate 8'h10 after the reset edge. Next line starts with r=0 pattern G,B (BAYER_PAT=0).

Source files
------------

// File: rtl/rgb2bayer_em.sv
// rgb2bayer_em: sensor-side emulator.
//
// Re-mosaics an RGB pixel stream into an 8-bit Bayer byte stream with embedded
// FF,00,00,XY sync codes. The output matches what the camera-input path
// decodes, so the capture pipeline can be looped back without a CMOS sensor.
//
// Parameters:
//   BAYER_PAT  - mosaic order of the first frame line: 0=GBRG 1=GRBG 2=BGGR 3=RGGB
//   MIN_HBLANK - minimum lv-low gap (cycles) for SAV/EAV to fit without collision
//
// Ports:
//   pixclk     in   pixel clock, single domain
//   rst        in   synchronous reset, active low
//   rgb_fv     in   frame valid
//   rgb_lv     in   line valid, one pixel per cycle while high
//   data_r/g/b in   8-bit colour samples
//   bayer_data out  embedded-sync Bayer byte stream
//   bayer_fv   out  rgb_fv delayed to align with bayer_data
//   bayer_lv   out  high only on pixel bytes of active lines
//   sync_err   out  sticky: a line started before the previous EAV completed
//
// Timing: a pixel sampled at edge t is visible on bayer_data in cycle t+5. SAV
// is launched directly from the lv rise so its four bytes fill cycles t+1..t+4,
// ahead of the first pixel. EAV follows the last pixel immediately.

module rgb2bayer_em #(
    parameter int unsigned BAYER_PAT  = 0,
    parameter int unsigned MIN_HBLANK = 8
) (
    input  logic       pixclk,
    input  logic       rst,
    input  logic       rgb_fv,
    input  logic       rgb_lv,
    input  logic [7:0] data_r,
    input  logic [7:0] data_g,
    input  logic [7:0] data_b,
    output logic [7:0] bayer_data,
    output logic       bayer_fv,
    output logic       bayer_lv,
    output logic       sync_err
);

    localparam logic [1:0] Pat = 2'(BAYER_PAT);

    localparam int unsigned GapW =
        ($clog2(MIN_HBLANK + 1) > 0) ? $clog2(MIN_HBLANK + 1) : 1;
    localparam logic [GapW-1:0] GapMax = GapW'(MIN_HBLANK);

    localparam logic [7:0] IdleByte   = 8'h10;
    localparam logic [7:0] SavActive  = 8'h80;
    localparam logic [7:0] EavActive  = 8'h9D;
    localparam logic [7:0] SavBlank   = 8'hAB;
    localparam logic [7:0] EavBlank   = 8'hB6;

    typedef enum logic [1:0] {StIdle, StSav, StPix, StEav} state_e;

    // Input register (stage 0) followed by the delay line (stages 1..3);
    // the output register is the fifth stage.
    logic [3:0]      p_vld_q, p_fv_q;
    logic [3:0][7:0] p_pix_q;

    logic            fv_q;
    logic            r_q, r_d;
    logic            c_q, c_d;
    logic            v_q, v_d;
    logic [GapW-1:0] gap_q, gap_d;

    state_e          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [7:0]      data_q, data_d;
    logic            blv_q, blv_d;
    logic            bfv_q;
    logic            err_q, err_d;

    logic            lv_q;
    logic            lv_rise, lv_fall, fv_rise;
    logic            r_eff, c_eff;
    logic            is_green, is_red;
    logic [7:0]      raw_pix, clip_pix;
    logic [7:0]      sav_xy, eav_xy;

    assign lv_q    = p_vld_q[0];
    assign lv_rise = rgb_lv & ~lv_q;
    assign lv_fall = ~rgb_lv & lv_q;
    assign fv_rise = rgb_fv & ~fv_q;

    // Row parity clears on the fv rise before this cycle's pixel uses it, and
    // column parity restarts on the lv rise, so the first pixel is always c=0.
    assign r_eff = fv_rise ? 1'b0 : r_q;
    assign c_eff = lv_rise ? 1'b0 : c_q;

    // GBRG/GRBG have green where r==c, BGGR/RGGB where r!=c. On the non-green
    // site, red sits on odd rows for GBRG/BGGR and even rows for GRBG/RGGB.
    assign is_green = (r_eff ^ c_eff) ^ ~Pat[1];
    assign is_red   = r_eff ^ Pat[0];

    always_comb begin
        raw_pix = data_b;
        if (is_green) begin
            raw_pix = data_g;
        end else if (is_red) begin
            raw_pix = data_r;
        end
    end

    // Keep payload out of the preamble code space.
    always_comb begin
        clip_pix = raw_pix;
        if (raw_pix == 8'hFF) begin
            clip_pix = 8'hFE;
        end else if (raw_pix == 8'h00) begin
            clip_pix = 8'h01;
        end
    end

    // Input-side line bookkeeping.
    always_comb begin
        r_d = r_q;
        if (fv_rise) begin
            r_d = 1'b0;
        end else if (lv_fall && v_q) begin
            r_d = ~r_q;
        end

        c_d = rgb_lv ? ~c_eff : c_q;
        v_d = lv_rise ? rgb_fv : v_q;

        if (rgb_lv) begin
            gap_d = '0;
        end else if (gap_q == GapMax) begin
            gap_d = gap_q;
        end else begin
            gap_d = gap_q + 1'b1;
        end
    end

    // v_q is latched at the lv rise, so it is valid for SAV XY, the pixels and
    // the EAV of the same line. A newer rise aborts that EAV anyway.
    assign sav_xy = v_q ? SavActive : SavBlank;
    assign eav_xy = v_q ? EavActive : EavBlank;

    // Output state machine. A new lv rise always restarts SAV: whatever is left
    // of the previous line (pixels or EAV) is dropped in favour of it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = IdleByte;
        blv_d   = 1'b0;
        err_d   = err_q;

        if (lv_rise) begin
            state_d = StSav;
            cnt_d   = 2'd1;
            data_d  = 8'hFF;
            if ((state_q != StIdle) || (gap_q < GapMax)) begin
                err_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    data_d = IdleByte;
                end
                StSav: begin
                    data_d = (cnt_q == 2'd3) ? sav_xy : 8'h00;
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = StPix;
                    end
                end
                StPix: begin
                    if (p_vld_q[3]) begin
                        data_d = v_q ? p_pix_q[3] : IdleByte;
                        blv_d  = v_q;
                    end else begin
                        data_d  = 8'hFF;
                        state_d = StEav;
                        cnt_d   = 2'd1;
                    end
                end
                StEav: begin
                    data_d = (cnt_q == 2'd3) ? eav_xy : 8'h00;
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge pixclk) begin
        if (!rst) begin
            p_vld_q <= '0;
            p_fv_q  <= '0;
            p_pix_q <= '0;
            fv_q    <= 1'b0;
            r_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            gap_q   <= GapMax;
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            data_q  <= IdleByte;
            blv_q   <= 1'b0;
            bfv_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            p_vld_q <= {p_vld_q[2:0], rgb_lv};
            p_fv_q  <= {p_fv_q[2:0], rgb_fv};
            p_pix_q <= {p_pix_q[2:0], clip_pix};
            fv_q    <= rgb_fv;
            r_q     <= r_d;
            c_q     <= c_d;
            v_q     <= v_d;
            gap_q   <= gap_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            blv_q   <= blv_d;
            bfv_q   <= p_fv_q[3];
            err_q   <= err_d;
        end
    end

    assign bayer_data = data_q;
    assign bayer_fv   = bfv_q;
    assign bayer_lv   = blv_q;
    assign sync_err   = err_q;

endmodule

// File: tb/tb_rgb2bayer_em.sv
// Directed bench for rgb2bayer_em (BAYER_PAT=0, MIN_HBLANK=8).
// Each table row holds the inputs driven during one cycle and the outputs
// expected to be visible during that same cycle. Cycle k's inputs are sampled
// at the k-th rising edge; a pixel driven in cycle t shows up in cycle t+5.

module tb_rgb2bayer_em;

    localparam int NV = 296;
    localparam int TimeoutNs = 100000;

    typedef struct {
        logic       rst;
        logic       fv;
        logic       lv;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] exp_data;
        logic       exp_lv;
        logic       exp_fv;
        logic       exp_err;
        logic       chk;
    } vec_t;

    vec_t vec [NV];

    logic       pixclk = 1'b0;
    logic       rst;
    logic       rgb_fv, rgb_lv;
    logic [7:0] data_r, data_g, data_b;
    logic [7:0] bayer_data;
    logic       bayer_fv, bayer_lv, sync_err;

    int  applied = 0;
    int  miscompares = 0;
    bit  done = 1'b0;

    always #5 pixclk = ~pixclk;

    rgb2bayer_em #(
        .BAYER_PAT (0),
        .MIN_HBLANK(8)
    ) dut (
        .pixclk    (pixclk),
        .rst       (rst),
        .rgb_fv    (rgb_fv),
        .rgb_lv    (rgb_lv),
        .data_r    (data_r),
        .data_g    (data_g),
        .data_b    (data_b),
        .bayer_data(bayer_data),
        .bayer_fv  (bayer_fv),
        .bayer_lv  (bayer_lv),
        .sync_err  (sync_err)
    );

    initial begin
        #(TimeoutNs);
        if (!done) begin
            miscompares++;
            $display("FAIL timeout: vector loop did not finish within %0d ns", TimeoutNs);
            $display("== TEST FAILED ==");
            $finish;
        end
    end

    task automatic check_reset(input int k);
        if (bayer_data !== 8'h10 || bayer_lv !== 1'b0 || bayer_fv !== 1'b0 ||
            sync_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset state at vec %0d: data=%h lv=%b fv=%b err=%b",
                     k, bayer_data, bayer_lv, bayer_fv, sync_err);
        end
    endtask

    task automatic drive(input int a, input int z, input logic fv, input logic lv,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        for (int k = a; k <= z; k++) begin
            vec[k].fv = fv;
            vec[k].lv = lv;
            vec[k].r  = r;
            vec[k].g  = g;
            vec[k].b  = b;
        end
    endtask

    task automatic code4(input int a, input logic [7:0] xy);
        vec[a].exp_data   = 8'hFF;
        vec[a+1].exp_data = 8'h00;
        vec[a+2].exp_data = 8'h00;
        vec[a+3].exp_data = xy;
    endtask

    task automatic pix(input int a, input logic [7:0] d, input logic lv);
        vec[a].exp_data = d;
        vec[a].exp_lv   = lv;
    endtask

    task automatic ofv(input int a, input int z);
        for (int k = a; k <= z; k++) vec[k].exp_fv = 1'b1;
    endtask

    task automatic oerr(input int a, input int z);
        for (int k = a; k <= z; k++) vec[k].exp_err = 1'b1;
    endtask

    initial begin
        // Defaults: idle inputs, reset outputs expected.
        for (int k = 0; k < NV; k++) begin
            vec[k].rst      = 1'b1;
            vec[k].fv       = 1'b0;
            vec[k].lv       = 1'b0;
            vec[k].r        = 8'h00;
            vec[k].g        = 8'h00;
            vec[k].b        = 8'h00;
            vec[k].exp_data = 8'h10;
            vec[k].exp_lv   = 1'b0;
            vec[k].exp_fv   = 1'b0;
            vec[k].exp_err  = 1'b0;
            vec[k].chk      = 1'b1;
        end

        // Reset for two edges, then 20 idle cycles (2..21).
        vec[0].rst = 1'b0;
        vec[0].chk = 1'b0;
        vec[1].rst = 1'b0;

        // Two active 4-pixel lines, gap 10.
        drive(22, 51, 1'b1, 1'b0, 8'h11, 8'h22, 8'h33);
        drive(25, 28, 1'b1, 1'b1, 8'h11, 8'h22, 8'h33);
        drive(39, 42, 1'b1, 1'b1, 8'h11, 8'h22, 8'h33);
        code4(26, 8'h80);
        pix(30, 8'h22, 1'b1); pix(31, 8'h33, 1'b1); pix(32, 8'h22, 1'b1); pix(33, 8'h33, 1'b1);
        code4(34, 8'h9D);
        code4(40, 8'h80);
        pix(44, 8'h11, 1'b1); pix(45, 8'h22, 1'b1); pix(46, 8'h11, 1'b1); pix(47, 8'h22, 1'b1);
        code4(48, 8'h9D);
        ofv(27, 56);

        // Blanking line of 3 pixels.
        drive(60, 62, 1'b0, 1'b1, 8'h55, 8'h55, 8'h55);
        code4(61, 8'hAB);
        pix(65, 8'h10, 1'b0); pix(66, 8'h10, 1'b0); pix(67, 8'h10, 1'b0);
        code4(68, 8'hB6);

        // Clipping on G sites: G=FF, B=44, G=00.
        drive(75, 235, 1'b1, 1'b0, 8'h11, 8'h22, 8'h33);
        drive(78, 78, 1'b1, 1'b1, 8'h00, 8'hFF, 8'h00);
        drive(79, 79, 1'b1, 1'b1, 8'h00, 8'h55, 8'h44);
        drive(80, 80, 1'b1, 1'b1, 8'h77, 8'h00, 8'h77);
        code4(79, 8'h80);
        pix(83, 8'hFE, 1'b1); pix(84, 8'h44, 1'b1); pix(85, 8'h01, 1'b1);
        code4(86, 8'h9D);
        ofv(80, 240);

        // Gap of 3: second SAV overwrites the tail of line A and its EAV.
        drive(95, 98, 1'b1, 1'b1, 8'h11, 8'h22, 8'h33);
        drive(102, 105, 1'b1, 1'b1, 8'h11, 8'h22, 8'h33);
        code4(96, 8'h80);
        pix(100, 8'h11, 1'b1); pix(101, 8'h22, 1'b1); pix(102, 8'h11, 1'b1);
        code4(103, 8'h80);
        pix(107, 8'h22, 1'b1); pix(108, 8'h33, 1'b1); pix(109, 8'h22, 1'b1); pix(110, 8'h33, 1'b1);
        code4(111, 8'h9D);
        oerr(103, 263);

        // Ten clean 2-pixel lines, gap 10; rows alternate starting with R,G.
        for (int k = 0; k < 10; k++) begin
            int s;
            s = 116 + 12 * k;
            drive(s, s + 1, 1'b1, 1'b1, 8'h11, 8'h22, 8'h33);
            code4(s + 1, 8'h80);
            if (k % 2 == 0) begin
                pix(s + 5, 8'h11, 1'b1); pix(s + 6, 8'h22, 1'b1);
            end else begin
                pix(s + 5, 8'h22, 1'b1); pix(s + 6, 8'h33, 1'b1);
            end
            code4(s + 7, 8'h9D);
        end

        // New frame, reset during PIX of line 2, then another frame.
        drive(240, 262, 1'b1, 1'b0, 8'h11, 8'h22, 8'h33);
        drive(243, 246, 1'b1, 1'b1, 8'h11, 8'h22, 8'h33);
        drive(257, 262, 1'b1, 1'b1, 8'h11, 8'h22, 8'h33);
        code4(244, 8'h80);
        pix(248, 8'h22, 1'b1); pix(249, 8'h33, 1'b1); pix(250, 8'h22, 1'b1); pix(251, 8'h33, 1'b1);
        code4(252, 8'h9D);
        code4(258, 8'h80);
        pix(262, 8'h11, 1'b1); pix(263, 8'h22, 1'b1);
        ofv(245, 263);
        vec[263].rst = 1'b0;
        drive(266, 281, 1'b1, 1'b0, 8'h11, 8'h22, 8'h33);
        drive(269, 270, 1'b1, 1'b1, 8'h11, 8'h22, 8'h33);
        code4(270, 8'h80);
        pix(274, 8'h22, 1'b1); pix(275, 8'h33, 1'b1);
        code4(276, 8'h9D);
        ofv(271, 286);

        // Apply: check this cycle's outputs, drive this cycle's inputs.
        for (int k = 0; k < NV; k++) begin
            if (k == 2 || k == 264) begin
                check_reset(k);
            end
            if (vec[k].chk) begin
                applied++;
                if (bayer_data !== vec[k].exp_data || bayer_lv !== vec[k].exp_lv ||
                    bayer_fv !== vec[k].exp_fv || sync_err !== vec[k].exp_err) begin
                    miscompares++;
                    $display("FAIL vec %0d: got data=%h lv=%b fv=%b err=%b, want data=%h lv=%b fv=%b err=%b",
                             k, bayer_data, bayer_lv, bayer_fv, sync_err,
                             vec[k].exp_data, vec[k].exp_lv, vec[k].exp_fv, vec[k].exp_err);
                end
            end
            rst    = vec[k].rst;
            rgb_fv = vec[k].fv;
            rgb_lv = vec[k].lv;
            data_r = vec[k].r;
            data_g = vec[k].g;
            data_b = vec[k].b;
            @(posedge pixclk);
            #1;
        end

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        if (miscompares == 0) begin
            $display("== TEST PASSED ==");
        end else begin
            $display("== TEST FAILED ==");
        end
        $finish;
    end

endmodule
